// File: rtl/uart_tx_buffered_pkg.sv
// Shared constants for the buffered UART transmitter.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit to every frame.
package uart_tx_buffered_pkg;

  // Serializer states; the PARITY state exists only when the parity bit is built in
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

  // Byte pushed by the top level to acknowledge a completed program load
  localparam logic [7:0] ACK_BYTE = 8'hAA;

  // Even parity: XOR of all data bits
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Synchronous byte FIFO with registered full/empty flags.
// Read data is the current head, so it is valid in the same cycle as pop.
module sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic         full_q, full_d, empty_q, empty_d;
  logic [W-1:0] mem_q [0:(1<<AW)-1];
  logic         do_push, do_pop;

  // Flags are registered, so a pop never frees a slot for a push in the same cycle
  assign do_push = push && !full_q;
  assign do_pop  = pop  && !empty_q;

  // Next pointers and the flags they imply
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    empty_d  = (wr_ptr_d == rd_ptr_d);
  end

  // Pointer and flag registers; contents are discarded on reset by clearing pointers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign dout  = mem_q[rd_ptr_q[AW-1:0]];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO drained onto txd as 8N1 frames.
// Define UART_TX_PARITY_EN to append an even-parity bit (8E1).
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 434,
  parameter int FIFO_AW          = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       txd
);

  localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
  localparam int CW       = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  tx_state_e  state_q;
  logic [7:0] sh_q;
  logic [2:0] bit_idx_q;
  logic [CW-1:0] clk_cnt_q;
  logic       txd_q, empty_q, ovf_q;
`ifdef UART_TX_PARITY_EN
  logic       par_q;
`endif

  logic       fifo_pop, fifo_full, fifo_empty, bit_end;
  logic [7:0] fifo_dout;

  assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;
  assign bit_end  = (clk_cnt_q == CNT_LAST);

  sync_fifo #(.W(8), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (wr_en),
    .pop   (fifo_pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Serializer FSM; txd is registered from the current state, so it lags state by one clock
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      sh_q      <= '0;
      bit_idx_q <= '0;
      clk_cnt_q <= '0;
      txd_q     <= 1'b1;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      clk_cnt_q <= bit_end ? '0 : clk_cnt_q + CNT_ONE;
      if (wr_en && fifo_full) ovf_q <= 1'b1;
      // Drained means nothing queued and no frame in flight
      empty_q <= fifo_empty && (state_q == ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          txd_q     <= 1'b1;
          clk_cnt_q <= '0;
          if (!fifo_empty) begin
            sh_q      <= fifo_dout;
            bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
            par_q     <= even_parity(fifo_dout);
`endif
            state_q   <= ST_START;
          end
        end
        ST_START: begin
          txd_q <= 1'b0;
          if (bit_end) state_q <= ST_DATA;
        end
        ST_DATA: begin
          txd_q <= sh_q[0];
          if (bit_end) begin
            sh_q      <= sh_q >> 1;
            bit_idx_q <= bit_idx_q + 3'd1;
`ifdef UART_TX_PARITY_EN
            if (bit_idx_q == 3'd7) state_q <= ST_PARITY;
`else
            if (bit_idx_q == 3'd7) state_q <= ST_STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          txd_q <= par_q;
          if (bit_end) state_q <= ST_STOP;
        end
`endif
        ST_STOP: begin
          txd_q <= 1'b1;
          if (bit_end) state_q <= ST_IDLE;
        end
        default: begin
          txd_q   <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign txd      = txd_q;
  assign empty    = empty_q;
  assign full     = fifo_full;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with a behavioural UART receiver on txd.
module tb_uart_tx_buffered;
  import uart_tx_buffered_pkg::*;

  localparam int HALF = 2;
  localparam int AW   = 2;
  localparam int BITP = 2 * HALF;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11 * BITP + 1;
`else
  localparam int FRAME = 10 * BITP + 1;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, overflow, txd;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] rx_data[$];
  logic       rx_par[$];
  int         rx_t[$];
  int         rx_ferr = 0;

  uart_tx_buffered #(.CLK_PER_HALF_BIT(HALF), .FIFO_AW(AW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .txd      (txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model: detect start on a falling txd, sample each bit mid-period
  logic [7:0] rb;
  logic       rp, rok;
  int         rt0;
  always begin
    @(negedge clk);
    if (txd === 1'b0) begin
      rt0 = cyc;
      repeat (HALF) @(negedge clk);
      rok = (txd === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (BITP) @(negedge clk);
        rb[i] = txd;
      end
      rp = 1'b0;
`ifdef UART_TX_PARITY_EN
      repeat (BITP) @(negedge clk);
      rp = txd;
`endif
      repeat (BITP) @(negedge clk);
      if (txd !== 1'b1) rok = 1'b0;
      rx_data.push_back(rb);
      rx_par.push_back(rp);
      rx_t.push_back(rt0);
      if (!rok) rx_ferr++;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frames(input int n, input string tag);
    int k = 0;
    while (rx_data.size() < n && k < 4000) begin
      tick();
      k++;
    end
    check(tag, rx_data.size(), n);
  endtask

  task automatic clear_rx();
    rx_data.delete();
    rx_par.delete();
    rx_t.delete();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_txd", txd, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_ovf", overflow, 1'b0);

    // Single byte: exact start latency, drain timing
    repeat (5) tick();
    wr_en = 1'b1; wr_data = ACK_BYTE;
    tick();                                   // edge N
    wr_en = 1'b0;
    check("t1_txd_N", txd, 1'b1);
    check("t1_empty_N", empty, 1'b1);
    tick();                                   // N+1
    check("t1_txd_N1", txd, 1'b1);
    check("t1_empty_N1", empty, 1'b0);
    tick();                                   // N+2
    check("t1_txd_fall", txd, 1'b0);
    repeat (39) tick();                       // N+41
    check("t1_empty_N41", empty, 1'b0);
    tick(); tick();                           // N+43
    check("t1_empty_N43", empty, 1'b1);
    wait_frames(1, "t1_nframes");
    if (rx_data.size() >= 1) check("t1_byte", rx_data[0], 8'hAA);

    // Back-to-back frames with a single idle cycle between them
    repeat (10) tick();
    clear_rx();
    wr_en = 1'b1; wr_data = 8'h00; tick();
    wr_data = 8'hFF; tick();
    wr_en = 1'b0;
    wait_frames(2, "t2_nframes");
    if (rx_data.size() >= 2) begin
      check("t2_byte0", rx_data[0], 8'h00);
      check("t2_byte1", rx_data[1], 8'hFF);
      check("t2_gap", rx_t[1] - rx_t[0], FRAME);
    end

    // Full / overflow while the serializer is busy
    repeat (10) tick();
    clear_rx();
    wr_en = 1'b1; wr_data = 8'h11; tick();
    wr_en = 1'b0; tick();                     // 0x11 now in flight, FIFO empty
    wr_en = 1'b1;
    wr_data = 8'hA1; tick();
    wr_data = 8'hA2; tick();
    wr_data = 8'hA3; tick();
    check("t3_full_3", full, 1'b0);
    wr_data = 8'hA4; tick();
    check("t3_full_4", full, 1'b1);
    check("t3_ovf_4", overflow, 1'b0);
    wr_data = 8'hA5; tick();
    wr_en = 1'b0;
    check("t3_ovf_5", overflow, 1'b1);
    wait_frames(5, "t3_nframes");
    repeat (3 * FRAME) tick();
    check("t3_no_extra", rx_data.size(), 5);
    if (rx_data.size() >= 5) begin
      check("t3_b0", rx_data[0], 8'h11);
      check("t3_b1", rx_data[1], 8'hA1);
      check("t3_b2", rx_data[2], 8'hA2);
      check("t3_b3", rx_data[3], 8'hA3);
      check("t3_b4", rx_data[4], 8'hA4);
    end
    check("t3_ovf_sticky", overflow, 1'b1);
    check("t3_empty_end", empty, 1'b1);

    // Wrap-around: 20 bytes, pushed only when room is available
    do_reset();
    check("t4_ovf_clear", overflow, 1'b0);
    clear_rx();
    begin
      int sent = 0;
      int k = 0;
      while (sent < 20 && k < 4000) begin
        if (!full) begin
          wr_en = 1'b1; wr_data = 8'(sent + 1);
          sent++;
        end
        tick();
        wr_en = 1'b0;
        k++;
      end
    end
    wait_frames(20, "t4_nframes");
    begin
      int bad = 0;
      for (int i = 0; i < rx_data.size(); i++)
        if (rx_data[i] !== 8'(i + 1)) bad++;
      check("t4_order_errs", bad, 0);
    end
    check("t4_ovf", overflow, 1'b0);

    // Reset mid-frame during data bit 3 of 0x5A with two bytes queued
    repeat (10) tick();
    wr_en = 1'b1;
    wr_data = 8'h5A; tick();                  // edge N
    wr_data = 8'h33; tick();
    wr_data = 8'h44; tick();                  // N+2, txd just fell
    wr_en = 1'b0;
    repeat (17) tick();                       // N+19, inside data bit 3
    check("t5_bit3", txd, 1'b1);
    check("t5_empty_pre", empty, 1'b0);
    rstn = 1'b0;
    tick();
    check("t5_txd_rst", txd, 1'b1);
    check("t5_empty_rst", empty, 1'b1);
    check("t5_full_rst", full, 1'b0);
    rstn = 1'b1;
    repeat (2 * FRAME) tick();
    clear_rx();
    repeat (4 * FRAME) tick();
    check("t5_no_frames", rx_data.size(), 0);
    check("t5_txd_idle", txd, 1'b1);

`ifdef UART_TX_PARITY_EN
    // Even parity bit
    clear_rx();
    wr_en = 1'b1;
    wr_data = 8'h07; tick();
    wr_data = 8'h03; tick();
    wr_en = 1'b0;
    wait_frames(2, "t6_nframes");
    if (rx_data.size() >= 2) begin
      check("t6_b0", rx_data[0], 8'h07);
      check("t6_p0", rx_par[0], 1'b1);
      check("t6_b1", rx_data[1], 8'h03);
      check("t6_p1", rx_par[1], 1'b0);
    end
`endif

    check("framing_errs", rx_ferr, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
